// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan encoder and related display blocks.
// Segment order everywhere is {a,b,c,d,e,f,g} with a in bit 6.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic is_multi_hot(input logic [NUM_DIGITS-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

    // Only meaningful for a one-hot input.
    function automatic logic [1:0] onehot_index(input logic [NUM_DIGITS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from a 7-segment pattern to BCD plus digit/blank flags.
// Anything that is neither a digit nor blank reports bcd = BCD_NONE with both flags low.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       is_digit,
    output logic       is_blank
);

    always_comb begin
        bcd      = BCD_NONE;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_encoder.sv
// Recovers BCD digits from a multiplexed 7-segment display bus: samples the bus,
// waits for a (dig_en, seg) pair to stay stable, then latches the decoded digit.
module seg7_scan_encoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     dig_valid,
    output logic                      frame_done,
    output logic                      err,
    output state_e                    dbg_state
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [6:0]              seg_s_q, seg_s_d;
    logic [NUM_DIGITS-1:0]   en_s_q, en_s_d;
    logic [NUM_DIGITS-1:0]   en_prev_q, en_prev_d;
    logic [6:0]              trk_seg_q, trk_seg_d;
    logic [NUM_DIGITS-1:0]   trk_en_q, trk_en_d;
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;

    logic [3:0]            dec_bcd;
    logic                  dec_is_digit;
    logic                  dec_is_blank;
    logic                  same_pair;
    logic                  sample_one_hot;
    logic                  load;
    logic                  latch;
    logic [1:0]            idx;
    logic [NUM_DIGITS-1:0] latch_bits;

    seg7_pattern_decode u_decode (
        .pattern  (seg_s_q),
        .bcd      (dec_bcd),
        .is_digit (dec_is_digit),
        .is_blank (dec_is_blank)
    );

    always_comb begin
        seg_s_d   = seg;
        en_s_d    = dig_en;
        en_prev_d = en_s_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        trk_seg_d = trk_seg_q;
        trk_en_d  = trk_en_q;
        load      = 1'b0;
        latch     = 1'b0;

        sample_one_hot = is_one_hot(en_s_q);
        same_pair      = (en_s_q == trk_en_q) && (seg_s_q == trk_seg_q);
        idx            = onehot_index(en_s_q);

        case (state_q)
            ST_IDLE: begin
                if (sample_one_hot) load = 1'b1;
            end
            ST_TRACK: begin
                if (!sample_one_hot) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (same_pair) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end else begin
                    load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!sample_one_hot) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same_pair) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            state_d   = ST_TRACK;
            cnt_d     = CNT_ONE;
            trk_seg_d = seg_s_q;
            trk_en_d  = en_s_q;
        end

        // Reaching the threshold latches on this edge; this also covers STABLE_CYCLES == 1 on load.
        if (state_d == ST_TRACK && cnt_d == CNT_MAX) begin
            latch   = 1'b1;
            state_d = ST_HOLD;
        end

        latch_bits = latch ? (NUM_DIGITS'(1) << idx) : '0;

        digits_d = digits_q;
        valid_d  = valid_q;
        if (latch) begin
            digits_d[4*idx +: 4] = dec_bcd;
            valid_d[idx]         = dec_is_digit;
        end

        // Multi-hot reports only on the first sample of a multi-hot run.
        err_d = (is_multi_hot(en_s_q) && !is_multi_hot(en_prev_q))
              || (latch && !dec_is_digit && !dec_is_blank);

        // A full mask reports and clears; a latch on that same edge survives the clear.
        frame_d = (mask_q == '1);
        mask_d  = (frame_d ? '0 : mask_q) | latch_bits;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s_q   <= '0;
            en_s_q    <= '0;
            en_prev_q <= '0;
            trk_seg_q <= '0;
            trk_en_q  <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            digits_q  <= '1;
            valid_q   <= '0;
            mask_q    <= '0;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            seg_s_q   <= seg_s_d;
            en_s_q    <= en_s_d;
            en_prev_q <= en_prev_d;
            trk_seg_q <= trk_seg_d;
            trk_en_q  <= trk_en_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    assign digits     = digits_q;
    assign dig_valid  = valid_q;
    assign frame_done = frame_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Bench for seg7_scan_encoder with STABLE_CYCLES=4: table of hold windows plus
// hand-written multi-hot, glitch and mid-count reset sequences.
module tb_seg7_scan_encoder;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic        frame_done;
    logic        err;
    state_e      dbg_state;

    always #5 clk = ~clk;

    seg7_scan_encoder #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .dig_en     (dig_en),
        .digits     (digits),
        .dig_valid  (dig_valid),
        .frame_done (frame_done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int err_total = 0;
    int frame_total = 0;
    int err_base = 0;
    int frame_base = 0;

    // {digits[15:0], dig_valid[3:0], err pulses[3:0], frame pulses[3:0]}
    logic [27:0] exp_q[$];

    typedef struct {
        logic [3:0]  en;
        logic [6:0]  pat;
        int          hold;
        int          gap;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        int          exp_err;
        int          exp_frame;
    } vec_t;

    vec_t vecs[17];

    always @(negedge clk) begin
        err_total   += int'(err);
        frame_total += int'(frame_done);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic open_window(input logic [15:0] d, input logic [3:0] v, input int e, input int f);
        logic [3:0] e4;
        logic [3:0] f4;
        e4 = e[3:0];
        f4 = f[3:0];
        exp_q.push_back({d, v, e4, f4});
        err_base   = err_total;
        frame_base = frame_total;
    endtask

    task automatic close_window(input string name);
        logic [27:0] e;
        settle();
        e = exp_q.pop_front();
        check({name, " digits"}, int'(digits), int'(e[27:12]));
        check({name, " dig_valid"}, int'(dig_valid), int'(e[11:8]));
        check({name, " err pulses"}, err_total - err_base, int'(e[7:4]));
        check({name, " frame pulses"}, frame_total - frame_base, int'(e[3:0]));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        open_window(v.exp_digits, v.exp_valid, v.exp_err, v.exp_frame);
        dig_en = v.en;
        seg    = v.pat;
        repeat (v.hold) tick();
        if (v.gap > 0) begin
            dig_en = 4'b0000;
            seg    = SEG_BLANK;
            repeat (v.gap) tick();
        end
        close_window(name);
    endtask

    initial begin
        logic [6:0] bad_a;
        logic [6:0] bad_b;
        bad_a = 7'b1000001;
        bad_b = 7'b1010101;

        vecs[0]  = '{4'b0001, SEG_1,     3,  3, 16'hFFFF, 4'b0000, 0, 0};
        vecs[1]  = '{4'b0001, SEG_1,     5,  3, 16'hFFF1, 4'b0001, 0, 0};
        vecs[2]  = '{4'b0010, bad_a,     5,  3, 16'hFFF1, 4'b0001, 1, 0};
        vecs[3]  = '{4'b0011, SEG_BLANK, 4,  3, 16'hFFF1, 4'b0001, 1, 0};
        vecs[4]  = '{4'b0100, SEG_BLANK, 5,  3, 16'hFFF1, 4'b0001, 0, 0};
        vecs[5]  = '{4'b0001, SEG_3,     6,  0, 16'hFFF3, 4'b0001, 0, 0};
        vecs[6]  = '{4'b0010, SEG_9,     6,  0, 16'hFF93, 4'b0011, 0, 0};
        vecs[7]  = '{4'b0100, SEG_0,     6,  0, 16'hF093, 4'b0111, 0, 0};
        vecs[8]  = '{4'b1000, SEG_7,     6,  3, 16'h7093, 4'b1111, 0, 1};
        vecs[9]  = '{4'b1000, SEG_8,     5,  3, 16'h8093, 4'b1111, 0, 0};
        vecs[10] = '{4'b0010, SEG_5,     5,  3, 16'h8053, 4'b1111, 0, 0};
        vecs[11] = '{4'b0100, SEG_6,     5,  3, 16'h8653, 4'b1111, 0, 0};
        vecs[12] = '{4'b0001, SEG_2,     5,  3, 16'h8652, 4'b1111, 0, 1};
        vecs[13] = '{4'b0010, SEG_BLANK, 5,  3, 16'h86F2, 4'b1101, 0, 0};
        vecs[14] = '{4'b1000, bad_b,     12, 3, 16'hF6F2, 4'b0101, 1, 0};
        vecs[15] = '{4'b0001, SEG_4,     5,  3, 16'hF6F4, 4'b0101, 0, 0};
        vecs[16] = '{4'b0100, SEG_1,     5,  3, 16'hF1F4, 4'b0101, 0, 1};

        rst_n  = 1'b0;
        dig_en = 4'b0000;
        seg    = SEG_BLANK;
        repeat (2) tick();
        settle();
        check("reset digits", int'(digits), 32'hFFFF);
        check("reset dig_valid", int'(dig_valid), 0);
        check("reset err", int'(err), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset state", int'(dbg_state), int'(ST_IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Multi-hot held for several cycles: one err, FSM parked in IDLE, nothing latched.
        open_window(16'hF1F4, 4'b0101, 1, 0);
        dig_en = 4'b0101;
        seg    = SEG_3;
        repeat (6) tick();
        settle();
        check("multihot state", int'(dbg_state), int'(ST_IDLE));
        dig_en = 4'b0000;
        seg    = SEG_BLANK;
        repeat (3) tick();
        close_window("multihot");

        // Glitching segments on digit 2: never stable for 4 samples.
        open_window(16'hF1F4, 4'b0101, 0, 0);
        dig_en = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            seg = (i % 2 == 0) ? SEG_1 : SEG_2;
            repeat (2) tick();
        end
        dig_en = 4'b0000;
        seg    = SEG_BLANK;
        repeat (3) tick();
        close_window("glitch");

        // Reset at count 3, then a full hold after release.
        dig_en = 4'b0001;
        seg    = SEG_8;
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        settle();
        check("midreset digits", int'(digits), 32'hFFFF);
        check("midreset dig_valid", int'(dig_valid), 0);
        check("midreset err", int'(err), 0);
        check("midreset frame_done", int'(frame_done), 0);
        check("midreset state", int'(dbg_state), int'(ST_IDLE));
        rst_n = 1'b1;
        open_window(16'hFFF8, 4'b0001, 0, 0);
        repeat (5) tick();
        dig_en = 4'b0000;
        seg    = SEG_BLANK;
        repeat (3) tick();
        close_window("post reset");

        check("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
